// File: rtl/wm8731_pkg.sv
// Shared types and default sizing for the WM8731-style I2S DAC transmitter.
package wm8731_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BCLK_HALF_DEF = 4;
    localparam int DATA_W_DEF    = 16;

endpackage

// File: rtl/i2s_dac_tx_bclk_gen.sv
// BCLK divider and frame bit counter; strobes mark the m_clk cycle before each b_clk edge.
module bclk_gen
    import wm8731_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    localparam int DIV_W    = $clog2(2 * BCLK_HALF),
    localparam int BIT_W    = $clog2(2 * DATA_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stop,
    output logic             b_clk,
    output logic             rise,
    output logic             fall,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * BCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0] div_cnt;

    assign rise = run && (div_cnt == '0);
    assign fall = run && (div_cnt == DIV_HALF);

    // stop clears everything on the frame-boundary edge so b_clk never rises again
    always_ff @(posedge clk) begin
        if (reset || !run || stop) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            b_clk   <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (rise) begin
                b_clk   <= 1'b1;
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else if (fall) begin
                b_clk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S (left-justified-by-one-slot-free) DAC transmitter: holding register, frame shifter, IDLE/RUN control.
// state | meaning
// IDLE  | outputs low, counters held at 0, handshake still accepts a pair
// RUN   | b_clk toggling, frames shifted out; leaves only at a frame boundary
module i2s_dac_tx
    import wm8731_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              m_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              b_clk,
    output logic              dac_lr_clk,
    output logic              dacdat,
    output logic              underrun
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int BIT_W   = $clog2(2 * DATA_W);

    state_t             state, state_nxt;
    logic               rise, fall, frame_start, stop, xfer, hold_full;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] hold_data, shift_reg, load_data;

    bclk_gen #(
        .BCLK_HALF (BCLK_HALF),
        .DATA_W    (DATA_W)
    ) u_bclk_gen (
        .clk     (m_clk),
        .reset   (reset),
        .run     (state == RUN),
        .stop    (stop),
        .b_clk   (b_clk),
        .rise    (rise),
        .fall    (fall),
        .bit_cnt (bit_cnt)
    );

    assign frame_start  = rise && (bit_cnt == '0);
    assign stop         = frame_start && !enable;
    assign sample_ready = !hold_full;
    assign xfer         = sample_valid && sample_ready;
    assign load_data    = hold_full ? hold_data : '0;

    always_ff @(posedge m_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (stop)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (reset) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            shift_reg  <= '0;
            dacdat     <= 1'b0;
            dac_lr_clk <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (xfer) hold_data <= {sample_l, sample_r};

            // a pair accepted in the frame-start cycle survives the load
            if (frame_start && !stop) hold_full <= xfer;
            else if (xfer)            hold_full <= 1'b1;

            if (stop) begin
                dacdat     <= 1'b0;
                dac_lr_clk <= 1'b0;
            end else if (frame_start) begin
                shift_reg  <= {load_data[FRAME_W-2:0], 1'b0};
                dacdat     <= load_data[FRAME_W-1];
                dac_lr_clk <= 1'b1;
                underrun   <= !hold_full;
            end else if (rise) begin
                shift_reg  <= {shift_reg[FRAME_W-2:0], 1'b0};
                dacdat     <= shift_reg[FRAME_W-1];
                dac_lr_clk <= (bit_cnt < BIT_W'(DATA_W));
            end
        end
    end

    // the fall strobe must only ever land in the high phase of b_clk
    assert property (@(posedge m_clk) disable iff (reset) fall |-> b_clk);

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench: frame-level reference model feeds expected frames; a bit-level receiver checks them.
module tb_i2s_dac_tx;

    localparam int H     = 4;
    localparam int DW    = 16;
    localparam int FW    = 2 * DW;
    localparam int PER   = 2 * H;
    localparam int FRAME = PER * FW;

    logic          m_clk = 1'b0;
    logic          reset, enable, sample_valid;
    logic [DW-1:0] sample_l, sample_r;
    logic          sample_ready, b_clk, dac_lr_clk, dacdat, underrun;

    int checks   = 0;
    int failures = 0;

    i2s_dac_tx #(.BCLK_HALF(H), .DATA_W(DW)) dut (
        .m_clk        (m_clk),
        .reset        (reset),
        .enable       (enable),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .b_clk        (b_clk),
        .dac_lr_clk   (dac_lr_clk),
        .dacdat       (dacdat),
        .underrun     (underrun)
    );

    always #5 m_clk = ~m_clk;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: pairs accepted go into hq; every frame start (every FRAME cycles
    // of RUN, the first on the entry cycle) consumes one pair or produces a zero frame.
    logic [FW-1:0] hq[$];
    logic [FW:0]   exp_q[$];
    bit            m_run = 0;
    int            rc = 0;
    bit            last_xfer = 0;

    always @(posedge m_clk) begin : model
        bit x;
        if (reset) begin
            m_run = 0; rc = 0; last_xfer = 0;
            hq.delete(); exp_q.delete();
        end else begin
            x = sample_valid && (hq.size() == 0);
            if (m_run) begin
                if (rc % FRAME == 0) begin
                    if (!enable) begin
                        m_run = 0; rc = 0;
                    end else begin
                        if (hq.size() != 0) exp_q.push_back({hq.pop_front(), 1'b0});
                        else                exp_q.push_back({{FW{1'b0}}, 1'b1});
                        rc++;
                    end
                end else begin
                    rc++;
                end
            end else if (enable) begin
                m_run = 1; rc = 0;
            end
            if (x) hq.push_back({sample_l, sample_r});
            last_xfer = x;
        end
    end

    // Receiver / monitor: samples pins mid-cycle, shifts dacdat on b_clk falling edges.
    int            cyc = 0, nb = 0, ur_cnt = 0;
    int            last_rise = -1000000, last_lr_rise = -1000000;
    logic [FW-1:0] word = '0;
    logic          p_b = 0, p_lr = 0, p_d = 0, p_ur = 0, p_lr_fall = 0;

    always @(negedge m_clk) begin : monitor
        logic [FW:0] e;
        cyc++;
        if (reset) begin
            nb = 0; ur_cnt = 0; p_lr_fall = 0;
            last_rise = -1000000; last_lr_rise = -1000000;
        end else begin
            if (m_run && (dacdat !== p_d || dac_lr_clk !== p_lr))
                chk(b_clk && !p_b, "chg_on_bclk_rise", {b_clk, p_b}, 2'b10);
            if (underrun) begin
                chk(!p_ur, "underrun_width", p_ur, 0);
                ur_cnt++;
            end
            if (b_clk && !p_b) begin
                if (cyc - last_rise <= 4 * H) chk(cyc - last_rise == PER, "bclk_period", cyc - last_rise, PER);
                last_rise = cyc;
            end
            if (!b_clk && p_b) begin
                chk(cyc - last_rise == H, "bclk_high", cyc - last_rise, H);
                if (dac_lr_clk && !p_lr_fall) nb = 0;
                if (nb != 0 || dac_lr_clk) begin
                    word = {word[FW-2:0], dacdat};
                    nb++;
                end
                p_lr_fall = dac_lr_clk;
                if (nb == FW) begin
                    nb = 0;
                    chk(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(word == e[FW:1], "frame_data", word, e[FW:1]);
                        chk(ur_cnt == int'(e[0]), "frame_underrun", ur_cnt, e[0]);
                    end
                    ur_cnt = 0;
                end
            end
            if (dac_lr_clk && !p_lr) begin
                if (cyc - last_lr_rise < 2 * FRAME)
                    chk(cyc - last_lr_rise == FRAME, "lrclk_period", cyc - last_lr_rise, FRAME);
                last_lr_rise = cyc;
            end
            if (!m_run)
                chk(!b_clk && !dac_lr_clk && !dacdat, "idle_pins", {b_clk, dac_lr_clk, dacdat}, 0);
            chk(sample_ready == (hq.size() == 0), "sample_ready", sample_ready, hq.size() == 0);
        end
        p_b = b_clk; p_lr = dac_lr_clk; p_d = dacdat; p_ur = underrun;
    end

    // Stimulus
    int mode = 0;

    task automatic drive();
        case (mode)
            1: begin
                sample_valid = 1'b1;
                if (last_xfer) begin
                    sample_l = sample_l + DW'(2);
                    sample_r = sample_r + DW'(2);
                end
            end
            2: begin
                sample_valid = ($urandom_range(0, 999) < 8);
                sample_l     = DW'($urandom);
                sample_r     = DW'($urandom);
            end
            default: sample_valid = 1'b0;
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge m_clk);
            #1;
            drive();
        end
    endtask

    task automatic check_quiet(input string tag);
        @(negedge m_clk);
        chk(b_clk == 1'b0,       {tag, "_bclk"},     b_clk, 0);
        chk(dac_lr_clk == 1'b0,  {tag, "_lrclk"},    dac_lr_clk, 0);
        chk(dacdat == 1'b0,      {tag, "_dacdat"},   dacdat, 0);
        chk(underrun == 1'b0,    {tag, "_underrun"}, underrun, 0);
        chk(sample_ready == 1'b1,{tag, "_ready"},    sample_ready, 1);
    endtask

    task automatic wait_bit(input int b, input string tag);
        int i;
        for (i = 0; i < 2 * FRAME; i++) begin
            if (m_run && (rc / PER) % FW == b && rc >= FRAME) break;
            step(1);
        end
        chk(i < 2 * FRAME, tag, i, 2 * FRAME);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
        step(3);
        reset = 1'b0;
        check_quiet("reset");

        // no samples: zero frames with underrun
        step(1);
        enable = 1'b1;
        step(2 * FRAME + 20);

        reset = 1'b1; enable = 1'b0;
        step(2);
        reset = 1'b0;

        // one pair pushed while idle, then start
        sample_l = 16'hA5C3; sample_r = 16'h3C5A; sample_valid = 1'b1;
        step(1);
        enable = 1'b1;
        step(FRAME + 50);

        // back-to-back incrementing pairs
        sample_l = 16'h0001; sample_r = 16'h0002; sample_valid = 1'b1; mode = 1;
        step(4 * FRAME);

        // sparse random pairs, some frames underrun
        mode = 2;
        step(8 * FRAME);

        // drop enable mid-frame; the frame must finish, then stay quiet
        mode = 0;
        wait_bit(10, "reach_bit10");
        enable = 1'b0;
        step(FRAME + 600);
        check_quiet("stopped");

        // reset mid-frame with a pair held
        sample_l = 16'h1234; sample_r = 16'h5678; sample_valid = 1'b1; mode = 1;
        enable = 1'b1;
        wait_bit(20, "reach_bit20");
        chk(hq.size() == 1, "pair_held", hq.size(), 1);
        mode = 0; sample_valid = 1'b0; reset = 1'b1; enable = 1'b0;
        @(posedge m_clk);
        check_quiet("midreset");
        @(posedge m_clk);
        #1;
        reset = 1'b0; enable = 1'b1;
        step(2 * FRAME + 20);
        enable = 1'b0;
        step(FRAME + 600);

        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
